// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - block-sum accumulator over a ripple-carry adder with carry extension
module sum_accumulator #(
  parameter int WIDTH       = 16,
  parameter int NUM_SAMPLES = 4,
  parameter int EXT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [EXT_W-1:0] out_ext,
  output logic             out_overflow
);

  localparam int CNT_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [EXT_W-1:0]   ext_q, ext_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   osum_q, osum_d;
  logic [EXT_W-1:0]   oext_q, oext_d;
  logic               oovf_q, oovf_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_c;
  logic [EXT_W-1:0]   ext_inc;
  logic               wrap;
  logic               accept;
  logic               last;

  // Full-adder ripple chain, carry-in tied low.
  always_comb begin
    logic carry;
    carry   = 1'b0;
    add_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = acc_q[i] ^ in_data[i] ^ carry;
      carry      = (acc_q[i] & in_data[i]) | (carry & (acc_q[i] ^ in_data[i]));
    end
    add_c = carry;
  end

  assign ext_inc = ext_q + EXT_W'(add_c);
  assign wrap    = add_c & (&ext_q);
  assign accept  = in_valid & in_ready;
  assign last    = (cnt_q == CNT_W'(NUM_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && !clear && last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  // A clear in ACCUM still completes the input handshake but drops the operand.
  always_comb begin
    acc_d  = acc_q;
    ext_d  = ext_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    osum_d = osum_q;
    oext_d = oext_q;
    oovf_d = oovf_q;
    if (state_q == ACCUM) begin
      if (clear) begin
        acc_d = '0;
        ext_d = '0;
        ovf_d = 1'b0;
        cnt_d = '0;
      end else if (accept) begin
        if (last) begin
          osum_d = add_sum;
          oext_d = ext_inc;
          oovf_d = ovf_q | wrap;
          acc_d  = '0;
          ext_d  = '0;
          ovf_d  = 1'b0;
          cnt_d  = '0;
        end else begin
          acc_d = add_sum;
          ext_d = ext_inc;
          ovf_d = ovf_q | wrap;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      ext_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      osum_q <= '0;
      oext_q <= '0;
      oovf_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ext_q  <= ext_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      osum_q <= osum_d;
      oext_q <= oext_d;
      oovf_q <= oovf_d;
    end
  end

  assign out_sum      = osum_q;
  assign out_ext      = oext_q;
  assign out_overflow = oovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed scoreboard bench for sum_accumulator
module tb_sum_accumulator;

  typedef struct packed {
    logic [15:0] s;
    logic [3:0]  e;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_clear = 1'b0, a_valid = 1'b0, a_out_ready = 1'b1;
  logic [15:0] a_data = '0;
  logic        a_in_ready, a_out_valid, a_ovf;
  logic [15:0] a_sum;
  logic [3:0]  a_ext;

  logic        b_clear = 1'b0, b_valid = 1'b0, b_out_ready = 1'b1;
  logic [15:0] b_data = '0;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [15:0] b_sum;
  logic [1:0]  b_ext;

  int checks = 0;
  int failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  longint unsigned tot_a = 0;
  int cnt_a = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.WIDTH(16), .NUM_SAMPLES(4), .EXT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear),
    .in_valid(a_valid), .in_ready(a_in_ready), .in_data(a_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_sum), .out_ext(a_ext), .out_overflow(a_ovf)
  );

  sum_accumulator #(.WIDTH(16), .NUM_SAMPLES(8), .EXT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_valid), .in_ready(b_in_ready), .in_data(b_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_sum), .out_ext(b_ext), .out_overflow(b_ovf)
  );

  function automatic exp_t mk_exp(input longint unsigned tot, input int ext_w);
    exp_t r;
    longint unsigned mask;
    mask = (64'd1 << ext_w) - 64'd1;
    r.s  = tot[15:0];
    r.e  = 4'((tot >> 16) & mask);
    r.o  = (tot >= (64'd1 << (16 + ext_w)));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand for one clock; the reference total follows only accepted, non-cleared operands.
  task automatic send_a(input logic [15:0] d, input logic clr);
    a_valid = 1'b1;
    a_data  = d;
    a_clear = clr;
    chk("a_in_ready_before_send", {31'd0, a_in_ready}, 32'd1);
    step();
    if (clr) begin
      tot_a = 0;
      cnt_a = 0;
    end else begin
      tot_a += d;
      cnt_a++;
      if (cnt_a == 4) begin
        q_a.push_back(mk_exp(tot_a, 4));
        tot_a = 0;
        cnt_a = 0;
      end
    end
    a_valid = 1'b0;
    a_clear = 1'b0;
  endtask

  task automatic check_out_a(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_out_valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({tag, "_queue_nonempty"}, {31'd0, q_a.size() != 0}, 32'd1);
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      chk({tag, "_out_sum"}, {16'd0, a_sum}, {16'd0, e.s});
      chk({tag, "_out_ext"}, {28'd0, a_ext}, {28'd0, e.e});
      chk({tag, "_out_overflow"}, {31'd0, a_ovf}, {31'd0, e.o});
    end
    if (a_out_ready) step();
  endtask

  initial begin
    exp_t e;
    int n;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_out_sum", {16'd0, a_sum}, 32'd0);
    chk("rst_out_ext", {28'd0, a_ext}, 32'd0);
    chk("rst_out_overflow", {31'd0, a_ovf}, 32'd0);
    rst_n = 1'b1;
    step();

    // Simple block, latency and single-cycle bubble
    a_out_ready = 1'b1;
    send_a(16'h0001, 1'b0);
    send_a(16'h0002, 1'b0);
    send_a(16'h0003, 1'b0);
    send_a(16'h0004, 1'b0);
    chk("t1_latency_out_valid", {31'd0, a_out_valid}, 32'd1);
    chk("t1_hold_in_ready", {31'd0, a_in_ready}, 32'd0);
    check_out_a("t1");
    chk("t1_after_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t1_after_in_ready", {31'd0, a_in_ready}, 32'd1);

    // Carry extension
    for (int i = 0; i < 4; i++) send_a(16'hFFFF, 1'b0);
    check_out_a("t2");

    // Backpressure with ignored input pulses during HOLD
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(16'h0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_valid = (i % 2 == 0);
      a_data  = 16'h5555;
      chk("t3_hold_out_valid", {31'd0, a_out_valid}, 32'd1);
      chk("t3_hold_out_sum", {16'd0, a_sum}, 32'h0040);
      chk("t3_hold_in_ready", {31'd0, a_in_ready}, 32'd0);
      step();
    end
    a_valid = 1'b0;
    check_out_a("t3");
    a_out_ready = 1'b1;
    step();
    chk("t3_release_out_valid", {31'd0, a_out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send_a(16'h0005, 1'b0);
    check_out_a("t3_next");

    // Narrow extension, long block: extension wraps and flags overflow
    for (int i = 0; i < 8; i++) begin
      b_valid = 1'b1;
      b_data  = 16'hFFFF;
      chk("t4_b_in_ready", {31'd0, b_in_ready}, 32'd1);
      step();
      if (i == 7) q_b.push_back(mk_exp(64'd8 * 64'hFFFF, 2));
    end
    b_valid = 1'b0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t4_out_valid", {31'd0, b_out_valid}, 32'd1);
    chk("t4_queue_nonempty", {31'd0, q_b.size() != 0}, 32'd1);
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      chk("t4_out_sum", {16'd0, b_sum}, {16'd0, e.s});
      chk("t4_out_ext", {30'd0, b_ext}, {28'd0, e.e});
      chk("t4_out_overflow", {31'd0, b_ovf}, {31'd0, e.o});
    end
    step();

    // Clear mid-block discards the partial sum and the concurrent operand
    send_a(16'h0100, 1'b0);
    send_a(16'h0200, 1'b0);
    send_a(16'h0300, 1'b1);
    chk("t5_after_clear_out_valid", {31'd0, a_out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send_a(16'h0001, 1'b0);
    check_out_a("t5");

    // Reset while holding a result
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(16'h0007, 1'b0);
    check_out_a("t6_pre");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t6_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("t6_rst_out_sum", {16'd0, a_sum}, 32'd0);
    tot_a = 0;
    cnt_a = 0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_a(16'h0002, 1'b0);
    check_out_a("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
